// File: rtl/gpio_pkg.sv
// Shared GPIO types: the pad-frame input bundle, the pin count, and the helper
// that turns the bundle into a plain vector indexed by pin number.
package gpio_pkg;

    localparam int NGPIO = 64;

    // First member is the MSB, so gpio0_i lands in the top bit of the packed struct.
    typedef struct packed {
        logic gpio0_i,  gpio1_i,  gpio2_i,  gpio3_i,  gpio4_i,  gpio5_i,  gpio6_i,  gpio7_i;
        logic gpio8_i,  gpio9_i,  gpio10_i, gpio11_i, gpio12_i, gpio13_i, gpio14_i, gpio15_i;
        logic gpio16_i, gpio17_i, gpio18_i, gpio19_i, gpio20_i, gpio21_i, gpio22_i, gpio23_i;
        logic gpio24_i, gpio25_i, gpio26_i, gpio27_i, gpio28_i, gpio29_i, gpio30_i, gpio31_i;
        logic gpio32_i, gpio33_i, gpio34_i, gpio35_i, gpio36_i, gpio37_i, gpio38_i, gpio39_i;
        logic gpio40_i, gpio41_i, gpio42_i, gpio43_i, gpio44_i, gpio45_i, gpio46_i, gpio47_i;
        logic gpio48_i, gpio49_i, gpio50_i, gpio51_i, gpio52_i, gpio53_i, gpio54_i, gpio55_i;
        logic gpio56_i, gpio57_i, gpio58_i, gpio59_i, gpio60_i, gpio61_i, gpio62_i, gpio63_i;
    } pad_to_gpio_t;

    function automatic logic [NGPIO-1:0] unpack_pad_to_gpio(input pad_to_gpio_t p);
        logic [NGPIO-1:0] u;
        u[0]  = p.gpio0_i;  u[1]  = p.gpio1_i;  u[2]  = p.gpio2_i;  u[3]  = p.gpio3_i;
        u[4]  = p.gpio4_i;  u[5]  = p.gpio5_i;  u[6]  = p.gpio6_i;  u[7]  = p.gpio7_i;
        u[8]  = p.gpio8_i;  u[9]  = p.gpio9_i;  u[10] = p.gpio10_i; u[11] = p.gpio11_i;
        u[12] = p.gpio12_i; u[13] = p.gpio13_i; u[14] = p.gpio14_i; u[15] = p.gpio15_i;
        u[16] = p.gpio16_i; u[17] = p.gpio17_i; u[18] = p.gpio18_i; u[19] = p.gpio19_i;
        u[20] = p.gpio20_i; u[21] = p.gpio21_i; u[22] = p.gpio22_i; u[23] = p.gpio23_i;
        u[24] = p.gpio24_i; u[25] = p.gpio25_i; u[26] = p.gpio26_i; u[27] = p.gpio27_i;
        u[28] = p.gpio28_i; u[29] = p.gpio29_i; u[30] = p.gpio30_i; u[31] = p.gpio31_i;
        u[32] = p.gpio32_i; u[33] = p.gpio33_i; u[34] = p.gpio34_i; u[35] = p.gpio35_i;
        u[36] = p.gpio36_i; u[37] = p.gpio37_i; u[38] = p.gpio38_i; u[39] = p.gpio39_i;
        u[40] = p.gpio40_i; u[41] = p.gpio41_i; u[42] = p.gpio42_i; u[43] = p.gpio43_i;
        u[44] = p.gpio44_i; u[45] = p.gpio45_i; u[46] = p.gpio46_i; u[47] = p.gpio47_i;
        u[48] = p.gpio48_i; u[49] = p.gpio49_i; u[50] = p.gpio50_i; u[51] = p.gpio51_i;
        u[52] = p.gpio52_i; u[53] = p.gpio53_i; u[54] = p.gpio54_i; u[55] = p.gpio55_i;
        u[56] = p.gpio56_i; u[57] = p.gpio57_i; u[58] = p.gpio58_i; u[59] = p.gpio59_i;
        u[60] = p.gpio60_i; u[61] = p.gpio61_i; u[62] = p.gpio62_i; u[63] = p.gpio63_i;
        return u;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO pin: synchronizer chain, persistence filter and commit-edge pulses.
// rise_o/fall_o are high in the cycle whose closing edge commits the new level.
module gpio_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_i,
    input  logic                 en_i,
    input  logic [DEB_CNT_W-1:0] deb_thresh_i,
    output logic                 sync_o,
    output logic                 stable_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    localparam logic [DEB_CNT_W:0] CNT_ONE = (DEB_CNT_W+1)'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_CNT_W-1:0]   cnt_q;
    logic                   stable_q;
    logic [DEB_CNT_W-1:0]   thresh_eff;
    logic [DEB_CNT_W:0]     cnt_inc;
    logic                   differ;
    logic                   commit;

    assign sync_o     = sync_q[SYNC_STAGES-1];
    assign stable_o   = stable_q;
    // A zero threshold would never let cnt+1 fall short, but it is clamped so it reads as T=1.
    assign thresh_eff = (deb_thresh_i == '0) ? DEB_CNT_W'(1) : deb_thresh_i;
    assign cnt_inc    = {1'b0, cnt_q} + CNT_ONE;
    assign differ     = sync_o != stable_q;
    assign commit     = en_i && differ && (cnt_inc >= {1'b0, thresh_eff});
    assign rise_o     = commit && sync_o;
    assign fall_o     = commit && !sync_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            if (!en_i || !differ) begin
                cnt_q <= '0;
            end else if (commit) begin
                stable_q <= sync_o;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_inc[DEB_CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gpio_input_sampler.sv
// Receive side of the GPIO pad mux: per-pin sync/filter instances plus the
// sticky interrupt status register and its combined interrupt line.
module gpio_input_sampler
    import gpio_pkg::*;
#(
    parameter int NGPIO       = gpio_pkg::NGPIO,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  pad_to_gpio_t         pad_to_gpio_i,
    input  logic [NGPIO-1:0]     en_i,
    input  logic [DEB_CNT_W-1:0] deb_thresh_i,
    input  logic [NGPIO-1:0]     rise_en_i,
    input  logic [NGPIO-1:0]     fall_en_i,
    input  logic [NGPIO-1:0]     irq_clr_i,
    output logic [NGPIO-1:0]     gpio_sync_o,
    output logic [NGPIO-1:0]     gpio_in_o,
    output logic [NGPIO-1:0]     irq_status_o,
    output logic                 irq_o
);

    logic [NGPIO-1:0] pad_vec;
    logic [NGPIO-1:0] rise;
    logic [NGPIO-1:0] fall;
    logic [NGPIO-1:0] status_q;

    assign pad_vec = unpack_pad_to_gpio(pad_to_gpio_i);

    for (genvar n = 0; n < NGPIO; n++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CNT_W  (DEB_CNT_W)
        ) u_deb (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .pad_i       (pad_vec[n]),
            .en_i        (en_i[n]),
            .deb_thresh_i(deb_thresh_i),
            .sync_o      (gpio_sync_o[n]),
            .stable_o    (gpio_in_o[n]),
            .rise_o      (rise[n]),
            .fall_o      (fall[n])
        );
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~irq_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
        end
    end

    assign irq_status_o = status_q;
    assign irq_o        = |status_q;

endmodule
